uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte queue and launch controller between `display_formatter` and `uart_tx`. It absorbs the formatter's single-cycle `tx_valid` byte pulses into a circular FIFO. It then replays them to `uart_tx` one at a time, issuing `tx_start` and obeying `tx_busy`. This decouples formatter pacing from the UART bit rate and reports overflow and idle status to the control path.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two.
- `AW`, default 4: pointer width, log2(`DEPTH`).
- `ACK_WAIT`, default 4: cycles to wait for `tx_busy` to rise after `tx_start`.

Ports (clock and reset first):
- `clk` in 1: system clock (`sys_clk` domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of FIFO contents and `overflow`.
- `wr_data` in 8: byte from the formatter.
- `wr_valid` in 1: single-cycle write strobe.
- `fmt_busy` out 1: backpressure to the formatter; high when `level >= DEPTH-1`.
- `overflow` out 1: sticky; set when a write is dropped.
- `level` out AW+1: current occupancy, 0..`DEPTH`.
- `empty` out 1: `level == 0`.
- `idle` out 1: `empty`, FSM in IDLE, and `tx_busy` low.
- `tx_start` out 1: one-cycle launch pulse to `uart_tx`.
- `tx_data` out 8: byte to transmit; held stable from `tx_start` until the return to IDLE.
- `tx_busy` in 1: from `uart_tx`.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr` (AW bits each, natural wrap) and a separate `level` counter, which disambiguates full from empty.
- **Write:** accepted when `wr_valid` is high and `level < DEPTH`, using the registered level. A write while full is dropped and sets `overflow`. A simultaneous pop does not rescue a write to a full FIFO.
- **Simultaneous accepted write and pop:** `level` is unchanged and both pointers advance.
- **FSM states:**
  - IDLE → LAUNCH when `!empty` and `!tx_busy`: load `tx_data` with the head byte, pop, and register `tx_start` = 1.
  - LAUNCH (1 cycle, `tx_start` high) → ACK.
  - ACK → DONE on `tx_busy` = 1. If `ACK_WAIT` cycles pass without `tx_busy`, go to IDLE (byte treated as sent).
  - DONE → GAP on `tx_busy` = 0.
  - GAP (1 cycle) → IDLE. This guarantees at least one idle cycle between launches.
- **Flush:** clears pointers, `level`, and `overflow` in one cycle. The FSM is not disturbed; a byte already launched completes. If `flush` and `wr_valid` occur in the same cycle, flush wins and the byte is dropped without setting `overflow`.
- **Reset:** all outputs are 0 except `empty` = 1 and `idle` = 1 (when `tx_busy` is low). The FSM returns to IDLE and pointers go to 0. Reset mid-transfer abandons the byte.

## Timing
- Accepted write at edge N makes `level`/`empty` update at N+1. `tx_start` is high for the cycle after N+2's IDLE evaluation, i.e. write at cycle 0 gives `tx_start` in cycle 2.
- Back-to-back bytes: the launch-to-launch interval is the UART frame time plus the GAP and LAUNCH overhead (≥3 cycles beyond `tx_busy` low).
- `fmt_busy`, `empty`, `level`, and `idle` are all registered-state derived, with no combinational path from `wr_valid`.

## Configuration
- Macro `TXQ_CRLF_EN`.
- **Defined:** when the head byte is 0x0A and the previously transmitted byte was not 0x0D, the queue launches 0x0D without popping, then launches 0x0A and pops. A one-bit `last_cr` register tracks the previous byte; flush and reset clear it.
- **Undefined:** bytes are transmitted verbatim and the `last_cr` logic is absent.

## Structure
- Shared package `txq_pkg` holds:
  - the FSM state encoding (IDLE, LAUNCH, ACK, DONE, GAP);
  - constants `ASCII_CR` = 8'h0D and `ASCII_LF` = 8'h0A.
- One sub-module, `txq_ram`: `DEPTH`×8 register array with one write port and one asynchronous read port. Pointer and level logic stay in the parent.

## Test plan
- Reset then write 0x41, 0x42: `tx_start` in cycle 2 with `tx_data` 0x41. With the model holding `tx_busy` for 10 cycles, the second `tx_start` carries 0x42 and `level` returns to 0.
- Hold `tx_busy` high and write 17 bytes at DEPTH 16: 16 are stored, `fmt_busy` is high from `level` 15 onward, `overflow` = 1, and the 17th byte is never transmitted.
- Flush with 5 queued bytes mid-transfer: the current byte completes, `level` = 0, `overflow` = 0, no further `tx_start`, and `idle` = 1 once `tx_busy` falls.
- `tx_busy` is never asserted: after `ACK_WAIT` cycles the FSM returns to IDLE and the next byte launches.
- With `TXQ_CRLF_EN`, write 0x31, 0x0A, 0x0D, 0x0A: transmitted sequence is 0x31, 0x0D, 0x0A, 0x0D, 0x0A. Without the macro it is 0x31, 0x0A, 0x0D, 0x0A.
- Assert `rst_n` low during DONE: `tx_start` = 0, `level` = 0, and the FSM is in IDLE immediately, asynchronously.

Source files
------------

// File: rtl/txq_pkg.sv
// Shared types and constants for the UART transmit queue.
package txq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_ACK    = 3'd2,
    ST_DONE   = 3'd3,
    ST_GAP    = 3'd4
  } txq_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef struct packed {
    logic       go;
    logic       pop;
    logic [7:0] data;
  } txq_launch_t;

endpackage

// File: rtl/txq_ram.sv
// DEPTH x 8 register file: one synchronous write port, one asynchronous read port.
module txq_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO between the display formatter and uart_tx, with a launch/ack FSM.
// Define TXQ_CRLF_EN to insert a CR ahead of any LF not already preceded by one.
module uart_tx_queue
  import txq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int ACK_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        fmt_busy,
  output logic        overflow,
  output logic [AW:0] level,
  output logic        empty,
  output logic        idle,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] BUSY_LVL = (AW+1)'(DEPTH-1);
  localparam int          CW       = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_WAIT-1);

  txq_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic [CW-1:0] ack_cnt_q;
  logic [7:0]    head;
  logic          wr_acc, wr_drop;
  txq_launch_t   lau;

  // Acceptance uses the registered level only; a same-cycle pop never frees a slot.
  assign wr_acc  = wr_valid && !flush && (level_q < FULL_LVL);
  assign wr_drop = wr_valid && !flush && (level_q >= FULL_LVL);

  txq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

`ifdef TXQ_CRLF_EN
  logic last_cr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_cr_q <= 1'b0;
    else if (flush)  last_cr_q <= 1'b0;
    else if (lau.go) last_cr_q <= (lau.data == ASCII_CR);
  end
`endif

  // Output/launch decision for the IDLE state.
  always_comb begin
    lau = '0;
    if (state_q == ST_IDLE && !empty && !tx_busy) begin
      lau.go   = 1'b1;
      lau.pop  = 1'b1;
      lau.data = head;
`ifdef TXQ_CRLF_EN
      if (head == ASCII_LF && !last_cr_q) begin
        lau.pop  = 1'b0;
        lau.data = ASCII_CR;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (lau.go) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_ACK;
      ST_ACK: begin
        if (tx_busy)                    state_d = ST_DONE;
        else if (ack_cnt_q == ACK_LAST) state_d = ST_IDLE;
      end
      ST_DONE:   if (!tx_busy) state_d = ST_GAP;
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ack_cnt_q  <= '0;
    end else begin
      tx_start_q <= lau.go;
      if (lau.go) tx_data_q <= lau.data;
      ack_cnt_q  <= (state_q == ST_ACK) ? ack_cnt_q + CW'(1) : '0;
    end
  end

  // Flush resets storage bookkeeping only; an in-flight byte keeps its FSM path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_acc)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (lau.pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_acc, lau.pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      if (wr_drop) overflow_q <= 1'b1;
    end
  end

  assign level    = level_q;
  assign empty    = (level_q == '0);
  assign fmt_busy = (level_q >= BUSY_LVL);
  assign overflow = overflow_q;
  assign idle     = empty && (state_q == ST_IDLE) && !tx_busy;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: scenario tasks against a byte-sequence reference model.
module tb_uart_tx_queue;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int ACK_WAIT = 4;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        fmt_busy, overflow, empty, idle, tx_start, tx_busy;
  logic [AW:0] level;
  logic [7:0]  tx_data;

  logic hold_busy = 1'b0;
  logic model_busy = 1'b0;
  int   busy_len = 6;
  bit   busy_en = 1'b1;
  assign tx_busy = hold_busy | model_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stab_viol = 0;
  int mcnt = 0;
  logic [7:0] log_q[$];
  int         log_cyc[$];

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .ACK_WAIT(ACK_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_valid(wr_valid),
    .fmt_busy(fmt_busy), .overflow(overflow), .level(level), .empty(empty), .idle(idle),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // uart_tx stand-in: logs launches and holds tx_busy for busy_len cycles.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt = 0;
      model_busy = 1'b0;
    end else begin
      if (tx_start) begin
        log_q.push_back(tx_data);
        log_cyc.push_back(cyc);
        mcnt = busy_en ? busy_len : 0;
      end else if (mcnt > 0) begin
        if (tx_data !== log_q[$]) stab_viol++;
        mcnt--;
      end
      model_busy = (mcnt > 0);
    end
  end

  function automatic bq_t expand(input bq_t src);
    bq_t o;
`ifdef TXQ_CRLF_EN
    logic [7:0] prev = 8'h00;
`endif
    foreach (src[i]) begin
`ifdef TXQ_CRLF_EN
      if (src[i] == 8'h0A && prev != 8'h0D) o.push_back(8'h0D);
      prev = src[i];
`endif
      o.push_back(src[i]);
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    hold_busy = 1'b0; busy_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (idle) begin ok = 1'b1; break; end
    end
  endtask

  task automatic write_burst(input bq_t b);
    foreach (b[i]) begin
      wr_data = b[i]; wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %0b want 0", tx_start); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b want 1", idle); end
    checks++; if ({fmt_busy, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {fmt_busy, overflow}); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
  endtask

  task automatic test_basic();
    int base;
    bit ok;
    do_reset();
    busy_len = 10;
    base = log_q.size();
    wr_data = 8'h41; wr_valid = 1'b1;
    tick();
    wr_data = 8'h42;
    @(negedge clk);
    checks++; if (level !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL basic_c1_level got %0d/%0b want 1/0", level, empty); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL basic_c1_start got %0b want 0", tx_start); end
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL basic_c2_launch got %0b/%h want 1/41", tx_start, tx_data); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL basic_c2_level got %0d want 1", level); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_drain got timeout want idle"); end
    checks++;
    if (log_q.size() - base != 2) begin errors++; $display("FAIL basic_count got %0d want 2", log_q.size() - base); end
    else begin
      checks++; if (log_q[base+1] !== 8'h42) begin errors++; $display("FAIL basic_second got %h want 42", log_q[base+1]); end
      checks++; if (log_cyc[base+1] - log_cyc[base] != 13) begin errors++; $display("FAIL basic_interval got %0d want 13", log_cyc[base+1] - log_cyc[base]); end
    end
    checks++; if (level !== '0) begin errors++; $display("FAIL basic_level_end got %0d want 0", level); end
  endtask

  task automatic test_overflow();
    int base, el;
    bit ok;
    bq_t b, st, exp;
    do_reset();
    busy_len = 4;
    hold_busy = 1'b1;
    base = log_q.size();
    for (int i = 0; i < DEPTH + 1; i++) b.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr_data = b[i]; wr_valid = 1'b1;
      tick();
      @(negedge clk);
      el = (i + 1 > DEPTH) ? DEPTH : i + 1;
      checks++; if (level !== (AW+1)'(el)) begin errors++; $display("FAIL ovf_level[%0d] got %0d want %0d", i, level, el); end
      checks++; if (fmt_busy !== (el >= DEPTH - 1)) begin errors++; $display("FAIL ovf_fmt_busy[%0d] got %0b want %0b", i, fmt_busy, el >= DEPTH - 1); end
    end
    wr_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    checks++; if (log_q.size() != base) begin errors++; $display("FAIL ovf_no_launch got %0d want 0", log_q.size() - base); end
    hold_busy = 1'b0;
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got timeout want idle"); end
    for (int i = 0; i < DEPTH; i++) st.push_back(b[i]);
    exp = expand(st);
    checks++;
    if (log_q.size() - base != exp.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", log_q.size() - base, exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (log_q[base+i] !== exp[i]) begin errors++; $display("FAIL ovf_byte[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_after_drain got %0b want 1", overflow); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_flush_clear got %0b want 0", overflow); end
  endtask

  task automatic test_flush();
    int base;
    bit ok, seen;
    bq_t b;
    do_reset();
    busy_len = 8;
    base = log_q.size();
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom_range(8'h20, 8'h7e)));
    write_burst(b);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); seen = tx_busy; end
    checks++; if (!seen) begin errors++; $display("FAIL flush_busy_seen got timeout want tx_busy"); end
    tick();
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (level !== '0 || empty !== 1'b1) begin errors++; $display("FAIL flush_level got %0d/%0b want 0/1", level, empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got %0b want 0", overflow); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_idle got timeout want idle"); end
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() - base != 1) begin errors++; $display("FAIL flush_count got %0d want 1", log_q.size() - base); end
    else begin
      checks++; if (log_q[base] !== b[0]) begin errors++; $display("FAIL flush_byte got %h want %h", log_q[base], b[0]); end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle_hold got %0b want 1", idle); end
  endtask

  task automatic test_ack_timeout();
    int base;
    bit ok;
    bq_t b;
    do_reset();
    busy_en = 1'b0;
    base = log_q.size();
    for (int i = 0; i < 2; i++) b.push_back(8'($urandom_range(8'h20, 8'h7e)));
    write_burst(b);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ackto_idle got timeout want idle"); end
    checks++;
    if (log_q.size() - base != 2) begin errors++; $display("FAIL ackto_count got %0d want 2", log_q.size() - base); end
    else begin
      checks++; if (log_q[base] !== b[0] || log_q[base+1] !== b[1]) begin errors++; $display("FAIL ackto_bytes got %h %h want %h %h", log_q[base], log_q[base+1], b[0], b[1]); end
      checks++; if (log_cyc[base+1] - log_cyc[base] != ACK_WAIT + 2) begin errors++; $display("FAIL ackto_interval got %0d want %0d", log_cyc[base+1] - log_cyc[base], ACK_WAIT + 2); end
    end
    busy_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int base, blen;
    bit ok;
    bq_t b, exp;
    do_reset();
    blen = $urandom_range(2, 12);
    busy_len = blen;
    base = log_q.size();
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom_range(0, 255)));
    write_burst(b);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle got timeout want idle"); end
    exp = expand(b);
    checks++;
    if (log_q.size() - base != exp.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", log_q.size() - base, exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (log_q[base+i] !== exp[i]) begin errors++; $display("FAIL b2b_byte[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
      if (i > 0) begin
        checks++;
        if (log_cyc[base+i] - log_cyc[base+i-1] != blen + 3) begin
          errors++; $display("FAIL b2b_interval[%0d] got %0d want %0d", i, log_cyc[base+i] - log_cyc[base+i-1], blen + 3);
        end
      end
    end
  endtask

  task automatic test_random();
    int base, w;
    bit ok;
    bq_t b, exp;
    logic [7:0] v;
    do_reset();
    busy_len = $urandom_range(2, 8);
    base = log_q.size();
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      w = 0;
      while (fmt_busy && w < 500) begin tick(); w++; end
      case ($urandom_range(0, 7))
        0:       v = 8'h0A;
        1:       v = 8'h0D;
        default: v = 8'($urandom_range(0, 255));
      endcase
      b.push_back(v);
      wr_data = v; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
    end
    wait_idle(6000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_idle got timeout want idle"); end
    exp = expand(b);
    checks++;
    if (log_q.size() - base != exp.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", log_q.size() - base, exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (log_q[base+i] !== exp[i]) begin errors++; $display("FAIL rand_byte[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_crlf();
    int base;
    bit ok;
    bq_t b, exp;
    do_reset();
    busy_len = 3;
    base = log_q.size();
    b = '{8'h31, 8'h0A, 8'h0D, 8'h0A};
`ifdef TXQ_CRLF_EN
    exp = '{8'h31, 8'h0D, 8'h0A, 8'h0D, 8'h0A};
`else
    exp = '{8'h31, 8'h0A, 8'h0D, 8'h0A};
`endif
    write_burst(b);
    wait_idle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL crlf_idle got timeout want idle"); end
    checks++;
    if (log_q.size() - base != exp.size()) begin errors++; $display("FAIL crlf_count got %0d want %0d", log_q.size() - base, exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (log_q[base+i] !== exp[i]) begin errors++; $display("FAIL crlf_byte[%0d] got %h want %h", i, log_q[base+i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen;
    bq_t b;
    do_reset();
    busy_len = 10;
    base = log_q.size();
    for (int i = 0; i < 3; i++) b.push_back(8'($urandom_range(8'h20, 8'h7e)));
    write_burst(b);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); seen = tx_busy; end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_busy_seen got timeout want tx_busy"); end
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx got %0b/%h want 0/00", tx_start, tx_data); end
    checks++; if (level !== '0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_level got %0d/%0b want 0/1", level, empty); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rmid_idle got %0b want 1", idle); end
    tick();
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (log_q.size() - base != 1) begin errors++; $display("FAIL rmid_abandon got %0d want 1", log_q.size() - base); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_ack_timeout();
    test_back_to_back();
    test_crlf();
    test_random();
    test_reset_mid();
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL tx_data_stable got %0d changes want 0", stab_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
